ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage_pkg.sv | 51 +++++
 rtl/ex_mem_stage_alu.sv | 25 ++
 rtl/ex_mem_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared encodings for the EX stage: aluOp classes, function-field codes,
// ALU control codes and forwarding selects.
package ex_mem_stage_pkg;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpOr    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;

  typedef enum logic [1:0] {
    FwdReg   = 2'b00,
    FwdMemWb = 2'b01,
    FwdExMem = 2'b10
  } fwd_sel_e;

  // Unknown function codes fall back to ADD.
  function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] ctrl;
    ctrl = AluAdd;
    case (op)
      AluOpAdd: ctrl = AluAdd;
      AluOpSub: ctrl = AluSub;
      AluOpOr:  ctrl = AluOr;
      default: begin
        case (funct)
          FunctSub: ctrl = AluSub;
          FunctAnd: ctrl = AluAnd;
          FunctOr:  ctrl = AluOr;
          FunctSlt: ctrl = AluSlt;
          default:  ctrl = AluAdd;
        endcase
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_mem_stage_alu.sv
// 32-bit ALU: ADD, SUB, AND, OR and signed SLT; wraps modulo 2^32.
module alu32
  import ex_mem_stage_pkg::*;
(
  input  logic [3:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = a + b;
    case (control)
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluSlt:  result = {31'd0, ($signed(a) < $signed(b))};
      default: result = a + b;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding feeding the EX/MEM pipeline register.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int unsigned FWD_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regWr,
  input  logic        flush,
  input  logic [31:0] regRs_ID_EX,
  input  logic [31:0] regRt_ID_EX,
  input  logic [31:0] signext16to32_ID_EX,
  input  logic [4:0]  rs_ID_EX,
  input  logic [4:0]  rt_ID_EX,
  input  logic [4:0]  rd_ID_EX,
  input  logic        regDest_ID_EX,
  input  logic        aluSrcB_ID_EX,
  input  logic        memRead_ID_EX,
  input  logic        memWrite_ID_EX,
  input  logic        memToReg_ID_EX,
  input  logic        regWrite_ID_EX,
  input  logic [1:0]  aluOp_ID_EX,
  input  logic [31:0] writeData_MEM_WB,
  input  logic [4:0]  destReg_MEM_WB,
  input  logic        regWrite_MEM_WB,
  output logic [31:0] aluResult_EX_MEM,
  output logic [31:0] storeData_EX_MEM,
  output logic [4:0]  destReg_EX_MEM,
  output logic        zero_EX_MEM,
  output logic        memRead_EX_MEM,
  output logic        memWrite_EX_MEM,
  output logic        memToReg_EX_MEM,
  output logic        regWrite_EX_MEM,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB
);

  fwd_sel_e    fwd_a, fwd_b;
  logic [31:0] op_a, rt_fwd, op_b, alu_result;
  logic        alu_zero;
  logic [3:0]  alu_ctrl;
  logic [4:0]  dest_reg;

  // Register 0 never forwards; EX/MEM wins over MEM/WB.
  function automatic fwd_sel_e fwd_select(input logic [4:0] src, input logic ex_wr,
                                          input logic [4:0] ex_dst, input logic wb_wr,
                                          input logic [4:0] wb_dst);
    if (ex_wr && (ex_dst != 5'd0) && (ex_dst == src)) return FwdExMem;
    if (wb_wr && (wb_dst != 5'd0) && (wb_dst == src)) return FwdMemWb;
    return FwdReg;
  endfunction

  always_comb begin
    fwd_a = FwdReg;
    fwd_b = FwdReg;
    if (FWD_EN != 0) begin
      fwd_a = fwd_select(rs_ID_EX, regWrite_EX_MEM, destReg_EX_MEM, regWrite_MEM_WB,
                         destReg_MEM_WB);
      fwd_b = fwd_select(rt_ID_EX, regWrite_EX_MEM, destReg_EX_MEM, regWrite_MEM_WB,
                         destReg_MEM_WB);
    end
  end

  assign fwdA = fwd_a;
  assign fwdB = fwd_b;

  always_comb begin
    case (fwd_a)
      FwdExMem: op_a = aluResult_EX_MEM;
      FwdMemWb: op_a = writeData_MEM_WB;
      default:  op_a = regRs_ID_EX;
    endcase
    case (fwd_b)
      FwdExMem: rt_fwd = aluResult_EX_MEM;
      FwdMemWb: rt_fwd = writeData_MEM_WB;
      default:  rt_fwd = regRt_ID_EX;
    endcase
  end

  assign op_b     = aluSrcB_ID_EX ? signext16to32_ID_EX : rt_fwd;
  assign alu_ctrl = alu_decode(aluOp_ID_EX, signext16to32_ID_EX[5:0]);
  assign dest_reg = regDest_ID_EX ? rd_ID_EX : rt_ID_EX;

  alu32 u_alu (
    .control (alu_ctrl),
    .a       (op_a),
    .b       (op_b),
    .result  (alu_result),
    .zero    (alu_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      aluResult_EX_MEM <= 32'd0;
      storeData_EX_MEM <= 32'd0;
      destReg_EX_MEM   <= 5'd0;
      zero_EX_MEM      <= 1'b0;
      memRead_EX_MEM   <= 1'b0;
      memWrite_EX_MEM  <= 1'b0;
      memToReg_EX_MEM  <= 1'b0;
      regWrite_EX_MEM  <= 1'b0;
    end else if (regWr) begin
      aluResult_EX_MEM <= alu_result;
      storeData_EX_MEM <= rt_fwd;
      destReg_EX_MEM   <= dest_reg;
      zero_EX_MEM      <= alu_zero;
      memRead_EX_MEM   <= memRead_ID_EX;
      memWrite_EX_MEM  <= memWrite_ID_EX;
      memToReg_EX_MEM  <= memToReg_ID_EX;
      regWrite_EX_MEM  <= regWrite_ID_EX;
    end
  end

endmodule
